// File: rtl/execute_muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU are no-ops.
module execute_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        WriteHiE,
  input  logic        WriteLoE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] HiE,
  output logic [31:0] LoE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] op_q, op_d;
  logic        negl_q, negl_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sa, sb, go;
  logic [31:0] absa, absb;
  logic [32:0] msum;
  logic [63:0] mstep, prod;

  assign sa   = ~MulDivOpE[0] & SrcAE[31];
  assign sb   = ~MulDivOpE[0] & SrcBE[31];
  assign absa = sa ? -SrcAE : SrcAE;
  assign absb = sb ? -SrcBE : SrcBE;

  // Multiply: acc = {partial, multiplier}, add then shift right.
  assign msum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? op_q : 32'd0)};
  assign mstep = {msum, acc_q[31:1]};
  assign prod  = negl_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MULDIV_DIV_EN
  logic        div_q, div_d;
  logic        negh_q, negh_d;
  logic        dz_q, dz_d;
  logic [32:0] dtrial, ddiff;
  logic [63:0] dstep;
  logic [31:0] quo, rem;

  // Divide: acc = {remainder, dividend/quotient}, shift left and trial-subtract.
  assign dtrial = acc_q[63:31];
  assign ddiff  = dtrial - {1'b0, op_q};
  assign dstep  = ddiff[32] ? {dtrial[31:0], acc_q[30:0], 1'b0}
                            : {ddiff[31:0], acc_q[30:0], 1'b1};
  assign quo    = dz_q ? 32'hFFFF_FFFF
                : (negl_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem    = negh_q ? -acc_q[63:32] : acc_q[63:32];
  assign go     = StartE;
`else
  assign go     = StartE & ~MulDivOpE[1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    negl_d  = negl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    negh_d  = negh_q;
    dz_d    = dz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
          cnt_d   = 5'd0;
          negl_d  = sa ^ sb;
          acc_d   = {32'd0, absb};
          op_d    = absa;
`ifdef MULDIV_DIV_EN
          div_d   = MulDivOpE[1];
          negh_d  = sa;
          dz_d    = (SrcBE == 32'd0);
          if (MulDivOpE[1]) begin
            acc_d = {32'd0, absa};
            op_d  = absb;
          end
`endif
        end else begin
          if (WriteHiE) hi_d = SrcAE;
          if (WriteLoE) lo_d = SrcAE;
        end
      end
      S_RUN: begin
        acc_d = mstep;
`ifdef MULDIV_DIV_EN
        if (div_q) acc_d = dstep;
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          hi_d = rem;
          lo_d = quo;
        end
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      op_q    <= 32'd0;
      negl_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      negh_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      negl_q  <= negl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      negh_q  <= negh_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign BusyE = (state_q != S_IDLE);
  assign DoneE = done_q;
  assign HiE   = hi_q;
  assign LoE   = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: directed ops, HI/LO checked on DoneE.
// Division vectors run when MULDIV_DIV_EN is defined, no-op checks otherwise.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        WriteHiE, WriteLoE;
  logic        BusyE, DoneE;
  logic [31:0] HiE, LoE;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  execute_muldiv dut (
    .clk(clk), .reset(reset), .StartE(StartE),
    .MulDivOpE(MulDivOpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .WriteHiE(WriteHiE), .WriteLoE(WriteLoE),
    .BusyE(BusyE), .DoneE(DoneE), .HiE(HiE), .LoE(LoE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DoneE pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && DoneE) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sbq.pop_front();
        chk("hi", {32'd0, HiE}, {32'd0, e[63:32]});
        chk("lo", {32'd0, LoE}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input bit mtlo,
                        input bit mthi);
    logic [31:0] lo0, hi0;
    bit busy_bad, lo_bad;
    hi0 = HiE;
    lo0 = LoE;
    StartE = 1'b1;
    MulDivOpE = op;
    SrcAE = a;
    SrcBE = b;
    WriteHiE = mthi;
    sbq.push_back({eh, el});
    step();
    StartE = 1'b0;
    WriteHiE = 1'b0;
    if (mthi) chk("start_beats_mthi", {32'd0, HiE}, {32'd0, hi0});
    if (mtlo) begin
      WriteLoE = 1'b1;
      SrcAE = 32'hDEAD_BEEF;
    end
    busy_bad = 1'b0;
    lo_bad = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (BusyE !== 1'b1) busy_bad = 1'b1;
      if (LoE !== lo0) lo_bad = 1'b1;
      if (k < 32) step();
    end
    WriteLoE = 1'b0;
    chk("busy_run", {63'd0, busy_bad}, 64'd0);
    if (mtlo) chk("mtlo_ignored_busy", {63'd0, lo_bad}, 64'd0);
    step();
    chk("done_edge33", {62'd0, BusyE, DoneE}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    StartE = 1'b0;
    MulDivOpE = 2'b00;
    SrcAE = 32'd0;
    SrcBE = 32'd0;
    WriteHiE = 1'b0;
    WriteLoE = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_state", {BusyE, DoneE, 30'd0, HiE ^ LoE}, 64'd0);
    chk("rst_hilo", {HiE, LoE}, 64'd0);

    // MTHI, MTLO, and both together.
    WriteHiE = 1'b1;
    SrcAE = 32'h0000_1234;
    step();
    WriteHiE = 1'b0;
    chk("mthi", {32'd0, HiE}, 64'h1234);
    WriteHiE = 1'b1;
    WriteLoE = 1'b1;
    SrcAE = 32'h0000_A5A5;
    step();
    WriteHiE = 1'b0;
    WriteLoE = 1'b0;
    chk("mt_both", {HiE, LoE}, 64'h0000_A5A5_0000_A5A5);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    // Issued in the DoneE cycle of the previous op.
    run_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000,
           32'd1, 32'd0, 1'b1, 1'b1);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);
`else
    begin
      logic [63:0] hl0;
      hl0 = {HiE, LoE};
      StartE = 1'b1;
      MulDivOpE = 2'b10;
      SrcAE = 32'hFFFF_FFF9;
      SrcBE = 32'd2;
      step();
      StartE = 1'b0;
      chk("div_noop_busy", {62'd0, BusyE, DoneE}, 64'd0);
      chk("div_noop_hilo", {HiE, LoE}, hl0);
      repeat (36) step();
      chk("div_noop_later", {HiE, LoE}, hl0);
    end
`endif

    // Reset sampled at edge 10 of a MULTU aborts it.
    StartE = 1'b1;
    MulDivOpE = 2'b01;
    SrcAE = 32'd9;
    SrcBE = 32'd9;
    step();
    StartE = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {62'd0, BusyE, DoneE}, 64'd0);
    chk("abort_hilo", {HiE, LoE}, 64'd0);
    begin
      int dones;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
        if (DoneE) dones++;
        step();
      end
      chk("abort_no_done", 64'(dones), 64'd0);
    end

    // Reset together with StartE.
    reset = 1'b1;
    StartE = 1'b1;
    MulDivOpE = 2'b00;
    step();
    reset = 1'b0;
    StartE = 1'b0;
    chk("reset_beats_start", {63'd0, BusyE}, 64'd0);

    step();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
